// File: rtl/button_debounce_pkg.sv
// ---------------------------------------------------------------------------
// button_debounce_pkg
// Shared types and default constants for the front-panel button debouncer.
//   btn_state_e        : per-channel debounce state (IDLE, PRESS_WAIT, HELD,
//                        RELEASE_WAIT)
//   DEF_STABLE_TICKS   : default qualification length in sample ticks
//   DEF_REPEAT_DELAY   : default ticks held before the first auto-repeat
//   DEF_REPEAT_PERIOD  : default ticks between later auto-repeats
//   cnt_width()        : counter width able to hold 0..max_val (never 0)
// Optional feature macro used by the importers: BUTTON_DEBOUNCE_AUTO_REPEAT_EN
// ---------------------------------------------------------------------------
package button_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int unsigned DEF_STABLE_TICKS  = 8;
    localparam int unsigned DEF_REPEAT_DELAY  = 16;
    localparam int unsigned DEF_REPEAT_PERIOD = 4;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One button: 2-flop synchronizer, debounce FSM, qualification counter and
// (with BUTTON_DEBOUNCE_AUTO_REPEAT_EN defined) an auto-repeat counter.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   tick_i     in  one-cycle sample strobe (time base for all counting)
//   btn_i      in  raw asynchronous button, 1 = pressed
//   level_o    out registered debounced level
//   press_o    out one-cycle pulse on accepted press (and on auto-repeat)
//   release_o  out one-cycle pulse on accepted release
// ---------------------------------------------------------------------------
module debounce_channel
    import button_debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS  = DEF_STABLE_TICKS,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned      CNT_W    = $clog2(STABLE_TICKS + 1);
    // Acceptance happens on the tick that would make cnt+1 reach STABLE_TICKS.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             sync1_q, sync_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             enter_held;
    logic             repeat_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync_q  <= sync1_q;
        end
    end

    // A bounce always takes priority over a tick arriving in the same cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_held = 1'b0;
        release_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick_i) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d    = HELD;
                        cnt_d      = '0;
                        enter_held = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HELD: begin
                if (!sync_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (tick_i) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Level covers RELEASE_WAIT too: it only drops once the release is accepted.
        level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
        press_d = enter_held | repeat_fire;
    end

`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
    localparam int unsigned      REP_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned      REP_W       = cnt_width(REP_MAX);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_armed_q, rep_armed_d;   // first repeat already emitted

    // Counts only while settled in HELD; RELEASE_WAIT freezes it so a release
    // glitch resumes the cadence rather than restarting it.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        repeat_fire = 1'b0;
        if (enter_held) begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
        end else if ((state_q == HELD) && sync_q && tick_i) begin
            if (rep_cnt_q == (rep_armed_q ? PERIOD_LAST : DELAY_LAST)) begin
                repeat_fire = 1'b1;
                rep_cnt_d   = '0;
                rep_armed_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Debounces and edge-detects NUM_BTN raw front-panel buttons using the
// clock-enable divider's sample strobe as time base.
// Optional feature: define BUTTON_DEBOUNCE_AUTO_REPEAT_EN for auto-repeat
// press pulses while a button is held.
// Ports:
//   clk          in  system clock
//   rst_n        in  asynchronous active-low reset
//   tick         in  one-cycle sample strobe
//   btn_in       in  [NUM_BTN] raw buttons, 1 = pressed
//   btn_level    out [NUM_BTN] debounced levels
//   btn_press    out [NUM_BTN] one-cycle press (and auto-repeat) pulses
//   btn_release  out [NUM_BTN] one-cycle release pulses
// ---------------------------------------------------------------------------
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int          NUM_BTN       = 4,
    parameter int unsigned STABLE_TICKS  = DEF_STABLE_TICKS,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            debounce_channel #(
                .STABLE_TICKS  (STABLE_TICKS),
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .tick_i    (tick),
                .btn_i     (btn_in[gi]),
                .level_o   (btn_level[gi]),
                .press_o   (btn_press[gi]),
                .release_o (btn_release[gi])
            );
        end
    endgenerate

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Debounces and edge-detects raw front-panel push buttons that step and control the matrix multiply datapath.
- Consumes the one-cycle sample strobe from the clock-enable divider as its time base.
- Emits clean per-button levels plus single-cycle press/release pulses in the clk domain.

Parameters:
- NUM_BTN, 4, number of independent button channels.
- STABLE_TICKS, 8, consecutive ticks an input must hold a new value before it is accepted (min 1).
- REPEAT_DELAY, 16, ticks held before the first auto-repeat pulse (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 4, ticks between subsequent auto-repeat pulses (AUTO_REPEAT_EN only).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- tick  input  1  one-cycle sample strobe from the clock-enable divider.
- btn_in  input  NUM_BTN  raw asynchronous button inputs, 1 = pressed.
- btn_level  output  NUM_BTN  debounced level per button.
- btn_press  output  NUM_BTN  one-cycle pulse on accepted press (and auto-repeat).
- btn_release  output  NUM_BTN  one-cycle pulse on accepted release.

Behaviour:
- Reset, asynchronous, active-low; clock clk. Reset forces synchronizers to 0, all channels to IDLE, all counters to 0, btn_level/btn_press/btn_release = 0. Reset mid-operation discards in-progress counts and emits no pulses.
- Each btn_in bit passes through a 2-flop synchronizer (btn_sync); all decisions use btn_sync only.
- Per-channel FSM, counter width $clog2(STABLE_TICKS+1):
  - IDLE: btn_sync=1 -> PRESS_WAIT, cnt=0. A tick in IDLE is ignored.
  - PRESS_WAIT: btn_sync=0 -> IDLE (bounce, no pulse). Else on tick cnt++. On the tick where cnt+1 == STABLE_TICKS -> HELD.
  - HELD: btn_sync=0 -> RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT: btn_sync=1 -> HELD (bounce, no pulse). Else on tick cnt++. On the tick where cnt+1 == STABLE_TICKS -> IDLE.
- Bounce and tick in the same cycle: bounce wins; the state reverts and cnt is not incremented.
- Outputs are registered.
  - btn_level rises in the same cycle the FSM enters HELD and falls on entry to IDLE.
  - btn_press is high for exactly that first btn_level=1 cycle; btn_release for the first btn_level=0 cycle.
- Latency: from btn_in change, 2 clk (sync) + 1 clk (IDLE->WAIT) + STABLE_TICKS ticks + 1 clk register.
- Channels are fully independent; several pulses may assert in the same cycle.
- tick held high continuously is legal: it degenerates to counting clk cycles.

Optional Feature:
- Macro BUTTON_DEBOUNCE_AUTO_REPEAT_EN.
- Defined:
  - In HELD a per-channel repeat counter counts ticks, cleared on entry to HELD.
  - After REPEAT_DELAY ticks, emit a one-cycle btn_press pulse.
  - Then emit another every REPEAT_PERIOD ticks while in HELD.
  - Leaving HELD (to RELEASE_WAIT) freezes the counter. A bounce back to HELD resumes without clearing and without an extra press pulse.
- Undefined: no repeat counter is built; REPEAT_* parameters are ignored; btn_press fires once per accepted press.

Decomposition:
- Package button_debounce_pkg:
  - 2-bit state enum: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - Default constants for STABLE_TICKS, REPEAT_DELAY and REPEAT_PERIOD.
- Sub-module debounce_channel: one synchronizer + FSM + counters for a single bit.
- Top generate-instantiates NUM_BTN copies and concatenates outputs.

Test Plan:
- Bench setup: STABLE_TICKS=4, tick every 10 clk.
- Clean press: btn_in[0] 0->1 and held -> btn_level[0]=1 and one btn_press[0] pulse after the 4th tick post-sync; other bits stay 0.
- Bounce on press: btn_in[1] toggles 1/0 every 7 clk for 60 clk, then held 1 -> no pulse during bouncing; exactly one btn_press[1] 4 ticks after settling.
- Release with bounce: from HELD, drop btn_in[0] to 0 for 2 ticks, back to 1, then 0 held -> no release during glitch; btn_release[0] exactly once 4 ticks after final drop; no extra btn_press.
- Simultaneous: btn_in[2] and btn_in[3] rise in the same clk -> both btn_press bits pulse in the same cycle.
- Reset mid-PRESS_WAIT: assert rst_n=0 after 2 ticks -> all outputs 0 immediately; after release of reset with btn_in held 1, the full 4-tick qualification restarts.
- With BUTTON_DEBOUNCE_AUTO_REPEAT_EN, REPEAT_DELAY=3, REPEAT_PERIOD=2: hold btn_in[0] 12 ticks past acceptance -> btn_press pulses at acceptance, +3, +5, +7, +9, +11 ticks.
